calc_key_sequencer: RTL

- Front-end controller for the calculator datapath.
- Takes the six raw board pushbuttons (plus, minus, calc, hundreds, tens, ones) and runs each through a synchroniser and a debouncer.
- Arbitrates simultaneous presses and optionally auto-repeats held digit keys.
- Issues exactly one single-cycle command pulse per accepted key event to the Calculator's plus/minus/calc/h/t/o inputs; at most one command is active per cycle.

---
 rtl/calc_pkg.sv | 31 +++
 rtl/calc_key_sequencer_debounce.sv | 40 ++++
 rtl/calc_key_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - key indices, sequencer states and priority helper
package calc_pkg;

    localparam int KEY_CALC  = 0;
    localparam int KEY_PLUS  = 1;
    localparam int KEY_MINUS = 2;
    localparam int KEY_H     = 3;
    localparam int KEY_T     = 4;
    localparam int KEY_O     = 5;
    localparam int NUM_KEYS  = 6;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_ISSUE = 2'd1,
        SEQ_LOCK  = 2'd2
    } seq_state_e;

    // Lowest index wins, so the key order above is also the priority order.
    function automatic logic [NUM_KEYS-1:0] pick_first(input logic [NUM_KEYS-1:0] req);
        logic [NUM_KEYS-1:0] g;
        g = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (req[i]) begin
                g    = '0;
                g[i] = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/calc_key_sequencer_debounce.sv
// rtl/calc_key_sequencer_debounce.sv - two-flop synchroniser plus counting debouncer
module btn_debounce #(
    parameter int DB_CYCLES = 250000,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb,
    output logic rise
);

    logic             meta_q;
    logic             sync_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            cnt_q  <= '0;
            deb    <= 1'b0;
            rise   <= 1'b0;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
            rise   <= 1'b0;
            if (sync_q == deb) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                deb   <= sync_q;
                rise  <= sync_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/calc_key_sequencer.sv
// rtl/calc_key_sequencer.sv - debounce, auto-repeat, arbitrate and pulse calculator keys
module calc_key_sequencer
    import calc_pkg::*;
#(
    parameter int DB_CYCLES  = 250000,
    parameter int CNT_W      = 20,
    parameter int GAP        = 2,
    parameter int REPT_DELAY = 0,
    parameter int REPT_RATE  = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_plus,
    input  logic btn_minus,
    input  logic btn_calc,
    input  logic btn_h,
    input  logic btn_t,
    input  logic btn_o,
    output logic plus,
    output logic minus,
    output logic calc,
    output logic h,
    output logic t,
    output logic o,
    output logic key_busy
);

    logic [NUM_KEYS-1:0] btn_v;
    logic [NUM_KEYS-1:0] deb_w;
    logic [NUM_KEYS-1:0] rise_w;
    logic [NUM_KEYS-1:0] rpt_ev;
    logic [NUM_KEYS-1:0] ev;

    assign btn_v = {btn_o, btn_t, btn_h, btn_minus, btn_plus, btn_calc};

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        localparam bit RPT_EN = (REPT_DELAY > 0) && (k >= KEY_H);

        logic [CNT_W-1:0] rcnt_q;
        logic             rphase_q;
        logic             rev_q;

        btn_debounce #(
            .DB_CYCLES(DB_CYCLES),
            .CNT_W    (CNT_W)
        ) u_db (
            .clk (clk),
            .rst (rst),
            .raw (btn_v[k]),
            .deb (deb_w[k]),
            .rise(rise_w[k])
        );

        // Repeat timer: first threshold is the hold delay, then the repeat rate.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rcnt_q   <= '0;
                rphase_q <= 1'b0;
                rev_q    <= 1'b0;
            end else begin
                rev_q <= 1'b0;
                if (!RPT_EN || !deb_w[k]) begin
                    rcnt_q   <= '0;
                    rphase_q <= 1'b0;
                end else if (rcnt_q == (rphase_q ? CNT_W'(REPT_RATE - 1)
                                                 : CNT_W'(REPT_DELAY - 1))) begin
                    rcnt_q   <= '0;
                    rphase_q <= 1'b1;
                    rev_q    <= 1'b1;
                end else begin
                    rcnt_q <= rcnt_q + CNT_W'(1);
                end
            end
        end

        assign rpt_ev[k] = rev_q;
    end

    assign ev = rise_w | rpt_ev;

    seq_state_e          state_q;
    logic [NUM_KEYS-1:0] pend_q, pend_d;
    logic [NUM_KEYS-1:0] sel_q;
    logic [NUM_KEYS-1:0] cmd_q;
    logic [CNT_W-1:0]    gap_q;
    logic [NUM_KEYS-1:0] grant;
    logic                take;

    // LOCK hands straight to ISSUE when work is waiting, so IDLE costs no cycle.
    always_comb begin
        grant  = pick_first(pend_q);
        take   = (|pend_q) && ((state_q == SEQ_IDLE) ||
                               (state_q == SEQ_LOCK && gap_q == '0));
        pend_d = (pend_q | ev) & ~(take ? grant : '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SEQ_IDLE;
            pend_q  <= '0;
            sel_q   <= '0;
            cmd_q   <= '0;
            gap_q   <= '0;
        end else begin
            pend_q <= pend_d;
            cmd_q  <= '0;
            case (state_q)
                SEQ_IDLE: begin
                    if (take) begin
                        sel_q   <= grant;
                        state_q <= SEQ_ISSUE;
                    end
                end
                SEQ_ISSUE: begin
                    cmd_q   <= sel_q;
                    gap_q   <= CNT_W'(GAP - 1);
                    state_q <= SEQ_LOCK;
                end
                SEQ_LOCK: begin
                    if (gap_q != '0) begin
                        gap_q <= gap_q - CNT_W'(1);
                    end else if (take) begin
                        sel_q   <= grant;
                        state_q <= SEQ_ISSUE;
                    end else begin
                        state_q <= SEQ_IDLE;
                    end
                end
                default: state_q <= SEQ_IDLE;
            endcase
        end
    end

    assign calc     = cmd_q[KEY_CALC];
    assign plus     = cmd_q[KEY_PLUS];
    assign minus    = cmd_q[KEY_MINUS];
    assign h        = cmd_q[KEY_H];
    assign t        = cmd_q[KEY_T];
    assign o        = cmd_q[KEY_O];
    assign key_busy = (state_q != SEQ_IDLE) || (|pend_q);

endmodule
